// File: rtl/hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// hazard_scoreboard
//
// Hazard controller for the 5-stage pipeline. It produces:
//   * EX-operand forwarding selects (EX > MEM > WB priority),
//   * the load-use stall,
//   * a registered scoreboard for variable-latency ("long") operations,
//   * MEM-stage redirect flushes and the final PC select.
// The stall/flush/forward/issue outputs are combinational. The scoreboard
// (pending bitmap, outstanding count, sticky error) and the optional perf
// counter update on the rising clock edge.
//
// Parameters:
//   NUM_REGS     architectural registers; x0 is never pending
//   REG_ADDR_W   register address width (2**REG_ADDR_W >= NUM_REGS)
//   MAX_PENDING  maximum outstanding long ops (1..15)
//   STALL_CNT_W  width of the stall-cycle perf counter
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   id_*                          ID instruction qualifiers and addresses
//   ex_*, mem_*, wb_*             downstream stage writers (forwarding sources)
//   lu_done_i, lu_done_rd_i       long-unit completion and its destination
//   redirect_i, redirect_pc_sel_i MEM-stage taken branch/jump and PC source
//   pc/if_id/id_ex_stall_o        pipeline stalls
//   if_id/id_ex_flush_o           pipeline flushes
//   forward_a/b_select_o          00 none, 01 EX, 10 MEM, 11 WB
//   pc_sel_final_o                PC source (00 = PC+4)
//   lu_issue_o                    ID long op accepted this cycle
//   sb_full_o, sb_busy_o          outstanding count == MAX_PENDING / != 0
//   sb_err_o                      sticky: completion seen with nothing outstanding
//   stall_cycles_o                stall-cycle count
//
// Configuration:
//   HAZARD_PERF_EN  when defined, stall_cycles_o counts cycles with pc_stall_o
//                   set and saturates at all-ones. When it is undefined,
//                   stall_cycles_o is tied to 0 and no counter is built.
// -----------------------------------------------------------------------------
module hazard_scoreboard #(
    parameter int NUM_REGS    = 32,
    parameter int REG_ADDR_W  = 5,
    parameter int MAX_PENDING = 4,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   id_valid_i,
    input  logic                   id_use_rs1_i,
    input  logic                   id_use_rs2_i,
    input  logic                   id_reg_write_i,
    input  logic                   id_long_op_i,
    input  logic [REG_ADDR_W-1:0]  id_rs1_addr_i,
    input  logic [REG_ADDR_W-1:0]  id_rs2_addr_i,
    input  logic [REG_ADDR_W-1:0]  id_rd_addr_i,
    input  logic                   ex_valid_i,
    input  logic                   ex_reg_write_i,
    input  logic                   ex_mem_read_i,
    input  logic                   ex_is_ctrl_i,
    input  logic [REG_ADDR_W-1:0]  ex_rd_addr_i,
    input  logic                   mem_valid_i,
    input  logic                   mem_reg_write_i,
    input  logic                   mem_is_ctrl_i,
    input  logic [REG_ADDR_W-1:0]  mem_rd_addr_i,
    input  logic                   wb_valid_i,
    input  logic                   wb_reg_write_i,
    input  logic [REG_ADDR_W-1:0]  wb_rd_addr_i,
    input  logic                   lu_done_i,
    input  logic [REG_ADDR_W-1:0]  lu_done_rd_i,
    input  logic                   redirect_i,
    input  logic [1:0]             redirect_pc_sel_i,
    output logic                   pc_stall_o,
    output logic                   if_id_stall_o,
    output logic                   id_ex_stall_o,
    output logic                   if_id_flush_o,
    output logic                   id_ex_flush_o,
    output logic [1:0]             forward_a_select_o,
    output logic [1:0]             forward_b_select_o,
    output logic [1:0]             pc_sel_final_o,
    output logic                   lu_issue_o,
    output logic                   sb_full_o,
    output logic                   sb_busy_o,
    output logic                   sb_err_o,
    output logic [STALL_CNT_W-1:0] stall_cycles_o
);

    // Four bits hold any MAX_PENDING in the supported 1..15 range.
    localparam int               CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PENDING);

    logic [NUM_REGS-1:0] pending;
    logic [CNT_W-1:0]    cnt;
    logic                sb_err;

    // One-hot register decode. Bit 0 is never produced, so x0 can never
    // become pending, and an out-of-range address decodes to nothing.
    function automatic logic [NUM_REGS-1:0] decode(input logic [REG_ADDR_W-1:0] addr);
        logic [NUM_REGS-1:0] onehot;
        onehot = '0;
        for (int i = 1; i < NUM_REGS; i++) begin
            if (addr == REG_ADDR_W'(i)) onehot[i] = 1'b1;
        end
        return onehot;
    endfunction

    function automatic logic [1:0] fwd_sel(
        input logic                  use_src,
        input logic [REG_ADDR_W-1:0] src,
        input logic                  ex_ok,
        input logic                  mem_ok,
        input logic                  wb_ok
    );
        logic [1:0] sel;
        sel = 2'b00;
        if (use_src) begin
            if (ex_ok && ex_rd_addr_i == src)        sel = 2'b01;
            else if (mem_ok && mem_rd_addr_i == src) sel = 2'b10;
            else if (wb_ok && wb_rd_addr_i == src)   sel = 2'b11;
        end
        return sel;
    endfunction

    // ---------------------------------------------------------------- forwarding
    // Each "ok" term already excludes rd == x0, so a match implies src != 0.
    logic ex_fwd_ok, mem_fwd_ok, wb_fwd_ok;

    assign ex_fwd_ok  = ex_valid_i  & ex_reg_write_i  & (ex_rd_addr_i  != '0);
    assign mem_fwd_ok = mem_valid_i & mem_reg_write_i & (mem_rd_addr_i != '0);
    assign wb_fwd_ok  = wb_valid_i  & wb_reg_write_i  & (wb_rd_addr_i  != '0);

    assign forward_a_select_o = fwd_sel(id_use_rs1_i, id_rs1_addr_i, ex_fwd_ok, mem_fwd_ok, wb_fwd_ok);
    assign forward_b_select_o = fwd_sel(id_use_rs2_i, id_rs2_addr_i, ex_fwd_ok, mem_fwd_ok, wb_fwd_ok);

    // ------------------------------------------------------------- hazard terms
    logic load_use, raw_sb, waw_sb, full_sb, ctrl_shadow, stall;

    assign sb_full_o = (cnt == CNT_MAX);
    assign sb_busy_o = (cnt != '0);
    assign sb_err_o  = sb_err;

    assign load_use = ex_valid_i & ex_mem_read_i & (ex_rd_addr_i != '0) &
                      ((id_use_rs1_i & (id_rs1_addr_i == ex_rd_addr_i)) |
                       (id_use_rs2_i & (id_rs2_addr_i == ex_rd_addr_i)));

    assign raw_sb = (id_use_rs1_i & |(pending & decode(id_rs1_addr_i))) |
                    (id_use_rs2_i & |(pending & decode(id_rs2_addr_i)));

    assign waw_sb      = id_reg_write_i & |(pending & decode(id_rd_addr_i));
    assign full_sb     = id_long_op_i & sb_full_o;
    // A long op never issues behind an unresolved branch/jump, so a redirect
    // never has to squash anything that is already in the scoreboard.
    assign ctrl_shadow = id_long_op_i & (ex_is_ctrl_i | mem_is_ctrl_i);

    assign stall = id_valid_i & (load_use | raw_sb | waw_sb | full_sb | ctrl_shadow);

    // ------------------------------------------------------ stall / flush / PC
    // A redirect squashes the instruction in ID, so it overrides any stall.
    assign pc_stall_o     = stall & ~redirect_i;
    assign if_id_stall_o  = pc_stall_o;
    assign id_ex_stall_o  = pc_stall_o;
    assign if_id_flush_o  = redirect_i;
    assign id_ex_flush_o  = redirect_i;
    assign pc_sel_final_o = redirect_i ? redirect_pc_sel_i : 2'b00;

    assign lu_issue_o = id_valid_i & id_long_op_i & ~stall & ~redirect_i;

    // --------------------------------------------------------------- scoreboard
    logic                done_ok;
    logic [NUM_REGS-1:0] issue_set;
    logic [NUM_REGS-1:0] done_clr;

    // A completion with nothing outstanding is dropped. It is only flagged.
    assign done_ok = lu_done_i & sb_busy_o;

    // NOTE: every variable written in always_comb gets a default first;
    // otherwise a path that skips the assignment infers a latch.
    always_comb begin
        issue_set = '0;
        done_clr  = '0;
        if (lu_issue_o && id_reg_write_i) issue_set = decode(id_rd_addr_i);
        if (done_ok)                      done_clr  = decode(lu_done_rd_i);
    end

    // NOTE: the bitmap is a flop vector, not a RAM, so it is cleared by the
    // asynchronous reset together with the count and the error flag.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            pending <= '0;
            cnt     <= '0;
            sb_err  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so that every
            // right-hand side sees the pre-edge value.
            // Issue and done cannot name the same rd (waw_sb blocks that issue),
            // so the set and clear masks never collide.
            pending <= (pending & ~done_clr) | issue_set;
            case ({lu_issue_o, done_ok})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (lu_done_i && !sb_busy_o) sb_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------ perf counter
`ifdef HAZARD_PERF_EN
    logic [STALL_CNT_W-1:0] stall_cycles;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            stall_cycles <= '0;
        end else if (pc_stall_o && stall_cycles != '1) begin
            stall_cycles <= stall_cycles + 1'b1;
        end
    end

    assign stall_cycles_o = stall_cycles;
`else
    assign stall_cycles_o = '0;
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
`timescale 1ns/1ps
module tb_hazard_scoreboard;

    localparam int NR = 32;
    localparam int AW = 5;
    localparam int MP = 4;
    localparam int SW = 32;

    logic          clk_i = 1'b0;
    logic          rst_i;
    logic          id_valid_i, id_use_rs1_i, id_use_rs2_i, id_reg_write_i, id_long_op_i;
    logic [AW-1:0] id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i;
    logic          ex_valid_i, ex_reg_write_i, ex_mem_read_i, ex_is_ctrl_i;
    logic [AW-1:0] ex_rd_addr_i;
    logic          mem_valid_i, mem_reg_write_i, mem_is_ctrl_i;
    logic [AW-1:0] mem_rd_addr_i;
    logic          wb_valid_i, wb_reg_write_i;
    logic [AW-1:0] wb_rd_addr_i;
    logic          lu_done_i;
    logic [AW-1:0] lu_done_rd_i;
    logic          redirect_i;
    logic [1:0]    redirect_pc_sel_i;
    logic          pc_stall_o, if_id_stall_o, id_ex_stall_o, if_id_flush_o, id_ex_flush_o;
    logic [1:0]    forward_a_select_o, forward_b_select_o, pc_sel_final_o;
    logic          lu_issue_o, sb_full_o, sb_busy_o, sb_err_o;
    logic [SW-1:0] stall_cycles_o;

    int checks   = 0;
    int failures = 0;

    hazard_scoreboard #(
        .NUM_REGS(NR), .REG_ADDR_W(AW), .MAX_PENDING(MP), .STALL_CNT_W(SW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .id_valid_i(id_valid_i), .id_use_rs1_i(id_use_rs1_i), .id_use_rs2_i(id_use_rs2_i),
        .id_reg_write_i(id_reg_write_i), .id_long_op_i(id_long_op_i),
        .id_rs1_addr_i(id_rs1_addr_i), .id_rs2_addr_i(id_rs2_addr_i), .id_rd_addr_i(id_rd_addr_i),
        .ex_valid_i(ex_valid_i), .ex_reg_write_i(ex_reg_write_i), .ex_mem_read_i(ex_mem_read_i),
        .ex_is_ctrl_i(ex_is_ctrl_i), .ex_rd_addr_i(ex_rd_addr_i),
        .mem_valid_i(mem_valid_i), .mem_reg_write_i(mem_reg_write_i), .mem_is_ctrl_i(mem_is_ctrl_i),
        .mem_rd_addr_i(mem_rd_addr_i),
        .wb_valid_i(wb_valid_i), .wb_reg_write_i(wb_reg_write_i), .wb_rd_addr_i(wb_rd_addr_i),
        .lu_done_i(lu_done_i), .lu_done_rd_i(lu_done_rd_i),
        .redirect_i(redirect_i), .redirect_pc_sel_i(redirect_pc_sel_i),
        .pc_stall_o(pc_stall_o), .if_id_stall_o(if_id_stall_o), .id_ex_stall_o(id_ex_stall_o),
        .if_id_flush_o(if_id_flush_o), .id_ex_flush_o(id_ex_flush_o),
        .forward_a_select_o(forward_a_select_o), .forward_b_select_o(forward_b_select_o),
        .pc_sel_final_o(pc_sel_final_o), .lu_issue_o(lu_issue_o),
        .sb_full_o(sb_full_o), .sb_busy_o(sb_busy_o), .sb_err_o(sb_err_o),
        .stall_cycles_o(stall_cycles_o)
    );

    always #5 clk_i = ~clk_i;

    // ------------------------------------------------------------- vector table
    typedef struct packed {
        logic          valid, u1, u2, wr, lng;
        logic [AW-1:0] rs1, rs2, rd;
        logic          exv, exw, exm, exc;
        logic [AW-1:0] exrd;
        logic          mv, mw, mc;
        logic [AW-1:0] mrd;
        logic          wv, ww;
        logic [AW-1:0] wrd;
        logic          redir;
        logic [1:0]    rsel;
        logic [1:0]    fa, fb;
        logic          st, fl;
        logic [1:0]    ps;
        logic          iss;
    } vec_t;

    vec_t vecs[$];

    // ------------------------------------------------------------ helpers
    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic idle();
        {id_valid_i, id_use_rs1_i, id_use_rs2_i, id_reg_write_i, id_long_op_i} = '0;
        {id_rs1_addr_i, id_rs2_addr_i, id_rd_addr_i} = '0;
        {ex_valid_i, ex_reg_write_i, ex_mem_read_i, ex_is_ctrl_i, ex_rd_addr_i} = '0;
        {mem_valid_i, mem_reg_write_i, mem_is_ctrl_i, mem_rd_addr_i} = '0;
        {wb_valid_i, wb_reg_write_i, wb_rd_addr_i} = '0;
        {lu_done_i, lu_done_rd_i, redirect_i, redirect_pc_sel_i} = '0;
    endtask

    task automatic do_reset();
        idle();
        rst_i = 1'b1;
        tick();
        tick();
        rst_i = 1'b0;
    endtask

    task automatic check_comb(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                              input logic st, input logic fl, input logic [1:0] ps, input logic iss);
        check({tag, ".fwd_a"},    forward_a_select_o, fa);
        check({tag, ".fwd_b"},    forward_b_select_o, fb);
        check({tag, ".pc_stall"}, pc_stall_o, st);
        check({tag, ".ifid_st"},  if_id_stall_o, st);
        check({tag, ".idex_st"},  id_ex_stall_o, st);
        check({tag, ".ifid_fl"},  if_id_flush_o, fl);
        check({tag, ".idex_fl"},  id_ex_flush_o, fl);
        check({tag, ".pc_sel"},   pc_sel_final_o, ps);
        check({tag, ".issue"},    lu_issue_o, iss);
    endtask

    task automatic apply(input vec_t v);
        id_valid_i = v.valid; id_use_rs1_i = v.u1; id_use_rs2_i = v.u2;
        id_reg_write_i = v.wr; id_long_op_i = v.lng;
        id_rs1_addr_i = v.rs1; id_rs2_addr_i = v.rs2; id_rd_addr_i = v.rd;
        ex_valid_i = v.exv; ex_reg_write_i = v.exw; ex_mem_read_i = v.exm;
        ex_is_ctrl_i = v.exc; ex_rd_addr_i = v.exrd;
        mem_valid_i = v.mv; mem_reg_write_i = v.mw; mem_is_ctrl_i = v.mc; mem_rd_addr_i = v.mrd;
        wb_valid_i = v.wv; wb_reg_write_i = v.ww; wb_rd_addr_i = v.wrd;
        redirect_i = v.redir; redirect_pc_sel_i = v.rsel;
        lu_done_i = 1'b0; lu_done_rd_i = '0;
    endtask

    // Observes which registers are pending by presenting each one as a used
    // rs1 with nothing else in flight; must start right after a tick.
    task automatic probe(input string name, input logic [NR-1:0] exp_mask);
        logic [NR-1:0] obs;
        idle();
        obs = '0;
        id_valid_i   = 1'b1;
        id_use_rs1_i = 1'b1;
        for (int r = 1; r < NR; r++) begin
            id_rs1_addr_i = AW'(r);
            #0.2;
            obs[r] = pc_stall_o;
        end
        check(name, obs, exp_mask);
        idle();
    endtask

    // --------------------------------------------------------- reference model
    bit [NR-1:0]     m_pend;
    int              m_cnt;
    bit              m_err;
    longint unsigned m_sc;

    function automatic logic [1:0] m_fwd(input logic u, input logic [AW-1:0] a);
        if (!u || a == 0) return 2'b00;
        if (ex_valid_i && ex_reg_write_i && ex_rd_addr_i == a) return 2'b01;
        if (mem_valid_i && mem_reg_write_i && mem_rd_addr_i == a) return 2'b10;
        if (wb_valid_i && wb_reg_write_i && wb_rd_addr_i == a) return 2'b11;
        return 2'b00;
    endfunction

    function automatic bit m_is_pend(input logic [AW-1:0] a);
        return (a != 0) && m_pend[a];
    endfunction

    function automatic bit m_stall();
        bit lu, raw, waw, full, ctrl;
        lu   = ex_valid_i && ex_mem_read_i && ex_rd_addr_i != 0 &&
               ((id_use_rs1_i && id_rs1_addr_i == ex_rd_addr_i) ||
                (id_use_rs2_i && id_rs2_addr_i == ex_rd_addr_i));
        raw  = (id_use_rs1_i && m_is_pend(id_rs1_addr_i)) ||
               (id_use_rs2_i && m_is_pend(id_rs2_addr_i));
        waw  = id_reg_write_i && m_is_pend(id_rd_addr_i);
        full = id_long_op_i && (m_cnt == MP);
        ctrl = id_long_op_i && (ex_is_ctrl_i || mem_is_ctrl_i);
        return id_valid_i && (lu || raw || waw || full || ctrl);
    endfunction

    task automatic model_edge(input bit st, input bit iss);
        bit done_ok;
        done_ok = lu_done_i && m_cnt > 0;
        if (lu_done_i && m_cnt == 0) m_err = 1'b1;
        if (done_ok) m_pend[lu_done_rd_i] = 1'b0;
        if (iss && id_reg_write_i && id_rd_addr_i != 0) m_pend[id_rd_addr_i] = 1'b1;
        m_cnt = m_cnt + int'(iss) - int'(done_ok);
`ifdef HAZARD_PERF_EN
        if (st && !redirect_i && m_sc != 64'hFFFF_FFFF) m_sc++;
`endif
    endtask

    // ---------------------------------------------------------------- stimulus
    initial begin
        bit [1:0] efa, efb, eps;
        bit       est, eiss;
        idle();
        rst_i = 1'b1;
        #2;
        check("rst.busy", sb_busy_o, 1'b0);
        check("rst.full", sb_full_o, 1'b0);
        check("rst.err", sb_err_o, 1'b0);
        check("rst.stall_cycles", stall_cycles_o, '0);

        // Combinational vectors, applied with the scoreboard held empty in reset.
        vecs.push_back('{valid:1'b1, u1:1'b1, rs1:5'd5, exv:1'b1, exw:1'b1, exrd:5'd5,
                         mv:1'b1, mw:1'b1, mrd:5'd5, wv:1'b1, ww:1'b1, wrd:5'd5, fa:2'b01, default:'0});
        vecs.push_back('{valid:1'b1, u1:1'b1, rs1:5'd5,
                         mv:1'b1, mw:1'b1, mrd:5'd5, wv:1'b1, ww:1'b1, wrd:5'd5, fa:2'b10, default:'0});
        vecs.push_back('{valid:1'b1, u1:1'b1, rs1:5'd5, wv:1'b1, ww:1'b1, wrd:5'd5, fa:2'b11, default:'0});
        vecs.push_back('{valid:1'b1, u1:1'b1, rs1:5'd0, exv:1'b1, exw:1'b1, exrd:5'd0,
                         mv:1'b1, mw:1'b1, mrd:5'd0, wv:1'b1, ww:1'b1, wrd:5'd0, default:'0});
        vecs.push_back('{valid:1'b1, u2:1'b1, rs1:5'd5, rs2:5'd5, exv:1'b1, exw:1'b1, exrd:5'd5,
                         fb:2'b01, default:'0});
        vecs.push_back('{valid:1'b1, u1:1'b1, rs1:5'd6, exv:1'b1, exrd:5'd6,
                         mv:1'b1, mrd:5'd6, wv:1'b1, ww:1'b1, wrd:5'd6, fa:2'b11, default:'0});
        // load-use on x7, then the same load in MEM
        vecs.push_back('{valid:1'b1, u2:1'b1, rs2:5'd7, exv:1'b1, exw:1'b1, exm:1'b1, exrd:5'd7,
                         fb:2'b01, st:1'b1, default:'0});
        vecs.push_back('{valid:1'b1, u2:1'b1, rs2:5'd7, mv:1'b1, mw:1'b1, mrd:5'd7,
                         fb:2'b10, default:'0});
        // redirect overrides the load-use stall
        vecs.push_back('{valid:1'b1, u2:1'b1, rs2:5'd7, exv:1'b1, exw:1'b1, exm:1'b1, exrd:5'd7,
                         redir:1'b1, rsel:2'b01, fb:2'b01, fl:1'b1, ps:2'b01, default:'0});
        vecs.push_back('{valid:1'b1, redir:1'b1, rsel:2'b10, fl:1'b1, ps:2'b10, default:'0});
        // load to x0, invalid EX load, invalid ID
        vecs.push_back('{valid:1'b1, u1:1'b1, rs1:5'd0, exv:1'b1, exw:1'b1, exm:1'b1, exrd:5'd0,
                         default:'0});
        vecs.push_back('{valid:1'b1, u1:1'b1, rs1:5'd3, exm:1'b1, exw:1'b1, exrd:5'd3, default:'0});
        vecs.push_back('{u1:1'b1, rs1:5'd3, exv:1'b1, exw:1'b1, exm:1'b1, exrd:5'd3,
                         fa:2'b01, default:'0});
        // long ops: control shadow, clean issue, issue squashed by redirect
        vecs.push_back('{valid:1'b1, lng:1'b1, wr:1'b1, rd:5'd9, mc:1'b1, st:1'b1, default:'0});
        vecs.push_back('{valid:1'b1, lng:1'b1, wr:1'b1, rd:5'd9, exc:1'b1, st:1'b1, default:'0});
        vecs.push_back('{valid:1'b1, lng:1'b1, wr:1'b1, rd:5'd9, iss:1'b1, default:'0});
        vecs.push_back('{valid:1'b1, lng:1'b1, wr:1'b1, rd:5'd9, redir:1'b1, rsel:2'b11,
                         fl:1'b1, ps:2'b11, default:'0});
        vecs.push_back('{lng:1'b1, wr:1'b1, rd:5'd9, default:'0});

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i]);
            #2;
            check_comb($sformatf("vec%0d", i), vecs[i].fa, vecs[i].fb, vecs[i].st,
                       vecs[i].fl, vecs[i].ps, vecs[i].iss);
            tick();
        end
        check("rst_hold.busy", sb_busy_o, 1'b0);

        // Long op to x9, dependents stall until the cycle after its completion.
        do_reset();
        id_valid_i = 1'b1; id_long_op_i = 1'b1; id_reg_write_i = 1'b1; id_rd_addr_i = 5'd9;
        #2 check("x9.issue", lu_issue_o, 1'b1);
        tick();
        for (int c = 1; c <= 6; c++) begin
            idle();
            id_valid_i = 1'b1; id_use_rs1_i = 1'b1; id_rs1_addr_i = 5'd9;
            if (c == 6) begin lu_done_i = 1'b1; lu_done_rd_i = 5'd9; end
            #2;
            check($sformatf("x9.stall_c%0d", c), pc_stall_o, 1'b1);
            check($sformatf("x9.busy_c%0d", c), sb_busy_o, 1'b1);
            tick();
        end
        idle();
        id_valid_i = 1'b1; id_use_rs1_i = 1'b1; id_rs1_addr_i = 5'd9;
        #2;
        check("x9.stall_c7", pc_stall_o, 1'b0);
        check("x9.busy_c7", sb_busy_o, 1'b0);
        tick();

        // Fill to MAX_PENDING, free a slot, refill, then issue and done together.
        do_reset();
        for (int r = 1; r <= 4; r++) begin
            idle();
            id_valid_i = 1'b1; id_long_op_i = 1'b1; id_reg_write_i = 1'b1; id_rd_addr_i = AW'(r);
            #2 check($sformatf("fill.issue_x%0d", r), lu_issue_o, 1'b1);
            tick();
        end
        idle();
        id_valid_i = 1'b1; id_long_op_i = 1'b1; id_reg_write_i = 1'b1; id_rd_addr_i = 5'd6;
        #2;
        check("fill.full", sb_full_o, 1'b1);
        check("fill.fifth_stall", pc_stall_o, 1'b1);
        check("fill.fifth_issue", lu_issue_o, 1'b0);
        tick();
        lu_done_i = 1'b1; lu_done_rd_i = 5'd2;
        #2 check("fill.done_full_issue", lu_issue_o, 1'b0);
        tick();
        lu_done_i = 1'b0;
        #2;
        check("fill.full_after_done", sb_full_o, 1'b0);
        check("fill.x6_issue", lu_issue_o, 1'b1);
        tick();
        probe("fill.pending_1346", 32'h0000_005A);
        check("fill.full_again", sb_full_o, 1'b1);
        tick();
        lu_done_i = 1'b1; lu_done_rd_i = 5'd1;
        tick();
        id_valid_i = 1'b1; id_long_op_i = 1'b1; id_reg_write_i = 1'b1; id_rd_addr_i = 5'd7;
        lu_done_i = 1'b1; lu_done_rd_i = 5'd3;
        #2 check("both.issue_x7", lu_issue_o, 1'b1);
        tick();
        idle();
        #1;
        check("both.full", sb_full_o, 1'b0);
        check("both.busy", sb_busy_o, 1'b1);
        tick();
        probe("both.pending_467", 32'h0000_00D0);

        // Completion with nothing outstanding, then asynchronous reset mid-stall.
        do_reset();
        lu_done_i = 1'b1; lu_done_rd_i = 5'd3;
        tick();
        idle();
        #2 check("err.set", sb_err_o, 1'b1);
        check("err.busy", sb_busy_o, 1'b0);
        tick(); tick();
        check("err.sticky", sb_err_o, 1'b1);
        id_valid_i = 1'b1; id_long_op_i = 1'b1; id_reg_write_i = 1'b1; id_rd_addr_i = 5'd9;
        tick();
        idle();
        id_valid_i = 1'b1; id_use_rs1_i = 1'b1; id_rs1_addr_i = 5'd9;
        tick();
        tick();
        #1 check("arst.stall_before", pc_stall_o, 1'b1);
        #1 rst_i = 1'b1;
        #1;
        check("arst.stall", pc_stall_o, 1'b0);
        check("arst.busy", sb_busy_o, 1'b0);
        check("arst.err", sb_err_o, 1'b0);
        check("arst.stall_cycles", stall_cycles_o, '0);
        tick();
        rst_i = 1'b0;

        // Three stall cycles on the perf counter.
        do_reset();
        id_valid_i = 1'b1; id_long_op_i = 1'b1; id_reg_write_i = 1'b1; id_rd_addr_i = 5'd9;
        tick();
        idle();
        id_valid_i = 1'b1; id_use_rs1_i = 1'b1; id_rs1_addr_i = 5'd9;
        tick(); tick(); tick();
        idle();
        #1;
`ifdef HAZARD_PERF_EN
        check("perf.three", stall_cycles_o, 32'd3);
`else
        check("perf.off", stall_cycles_o, 32'd0);
`endif

        // Randomized run against the reference model.
        do_reset();
        m_pend = '0; m_cnt = 0; m_err = 1'b0; m_sc = 0;
        for (int n = 0; n < 2000; n++) begin
            id_valid_i      = ($urandom_range(0, 7) != 0);
            id_use_rs1_i    = $urandom_range(0, 1);
            id_use_rs2_i    = $urandom_range(0, 1);
            id_reg_write_i  = ($urandom_range(0, 3) != 0);
            id_long_op_i    = ($urandom_range(0, 2) == 0);
            id_rs1_addr_i   = AW'($urandom_range(0, 7));
            id_rs2_addr_i   = AW'($urandom_range(0, 7));
            id_rd_addr_i    = AW'($urandom_range(0, 7));
            ex_valid_i      = $urandom_range(0, 1);
            ex_reg_write_i  = $urandom_range(0, 1);
            ex_mem_read_i   = ($urandom_range(0, 3) == 0);
            ex_is_ctrl_i    = ($urandom_range(0, 7) == 0);
            ex_rd_addr_i    = AW'($urandom_range(0, 7));
            mem_valid_i     = $urandom_range(0, 1);
            mem_reg_write_i = $urandom_range(0, 1);
            mem_is_ctrl_i   = ($urandom_range(0, 7) == 0);
            mem_rd_addr_i   = AW'($urandom_range(0, 7));
            wb_valid_i      = $urandom_range(0, 1);
            wb_reg_write_i  = $urandom_range(0, 1);
            wb_rd_addr_i    = AW'($urandom_range(0, 7));
            redirect_i      = ($urandom_range(0, 9) == 0);
            redirect_pc_sel_i = 2'($urandom_range(0, 3));
            lu_done_i       = (m_cnt > 0) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 39) == 0);
            lu_done_rd_i    = AW'($urandom_range(0, 7));
            #2;
            est  = m_stall();
            efa  = m_fwd(id_use_rs1_i, id_rs1_addr_i);
            efb  = m_fwd(id_use_rs2_i, id_rs2_addr_i);
            eps  = redirect_i ? redirect_pc_sel_i : 2'b00;
            eiss = id_valid_i && id_long_op_i && !est && !redirect_i;
            check_comb($sformatf("rnd%0d", n), efa, efb, est && !redirect_i, redirect_i, eps, eiss);
            check($sformatf("rnd%0d.busy", n), sb_busy_o, m_cnt != 0);
            check($sformatf("rnd%0d.full", n), sb_full_o, m_cnt == MP);
            check($sformatf("rnd%0d.err", n), sb_err_o, m_err);
            check($sformatf("rnd%0d.stall_cycles", n), stall_cycles_o, m_sc[SW-1:0]);
            model_edge(est, eiss);
            tick();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
